// File: rtl/llsc_pkg.sv
// Shared types and constants for the LL.W / SC.W atomic-access unit.
package llsc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DRAIN,
    S_DONE
  } llsc_state_e;

  localparam logic [5:0]  ECODE_ALE      = 6'h09;
  localparam int unsigned MEM_WORD_BYTES = 4;
  localparam int unsigned WORD_OFS_W     = $clog2(MEM_WORD_BYTES);

  function automatic logic is_misaligned(input logic [WORD_OFS_W-1:0] ofs);
    return ofs != '0;
  endfunction

endpackage

// File: rtl/llsc_unit_if.sv
// Issue, memory, writeback and LLBCTL signals of the LL/SC unit.
interface llsc_unit_if #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 6
);
  logic              op_valid;
  logic              op_ready;
  logic              op_is_sc;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [TAG_W-1:0]  op_tag;
  logic              llbit_i;
  logic              flush;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_rdata;

  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [31:0]       wb_data;
  logic              exc_valid;
  logic [5:0]        exc_ecode;
  logic [ADDR_W-1:0] exc_badv;
  logic              ll_o;
  logic              sc_o;

  // The unit itself.
  modport slave (
    input  op_valid, op_is_sc, op_addr, op_wdata, op_tag, llbit_i, flush,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output op_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           wb_valid, wb_tag, wb_data, exc_valid, exc_ecode, exc_badv, ll_o, sc_o
  );

  // Issue stage, memory and LLBCTL seen together.
  modport master (
    output op_valid, op_is_sc, op_addr, op_wdata, op_tag, llbit_i, flush,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  op_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           wb_valid, wb_tag, wb_data, exc_valid, exc_ecode, exc_badv, ll_o, sc_o
  );

endinterface

// File: rtl/llsc_unit.sv
// LL.W / SC.W execution unit: alignment check, LLbit-based SC decision,
// one memory transaction, writeback and single-cycle pulses to LLBCTL.
//
// state   | meaning
// IDLE    | waiting for an op; op_ready high unless flushing
// REQ     | memory request held until mem_req_ready
// RESP    | waiting for the single response
// DRAIN   | op flushed after the request left; swallow one response
// DONE    | one-cycle result: writeback, ALE report, ll/sc pulse
module llsc_unit
  import llsc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 6
) (
  input logic       clk,
  input logic       rst,
  llsc_unit_if.slave bus
);

  llsc_state_e       state_q;
  logic              is_sc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [TAG_W-1:0]  tag_q;

  logic              wb_valid_q;
  logic [TAG_W-1:0]  wb_tag_q;
  logic [31:0]       wb_data_q;
  logic              exc_valid_q;
  logic [5:0]        exc_ecode_q;
  logic [ADDR_W-1:0] exc_badv_q;
  logic              ll_q;
  logic              sc_q;

  logic              op_ready_w;
  logic              accept;

  assign op_ready_w = (state_q == S_IDLE) && !bus.flush;
  assign accept     = bus.op_valid && op_ready_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_sc_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_tag_q    <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_ecode_q <= '0;
      exc_badv_q  <= '0;
      ll_q        <= 1'b0;
      sc_q        <= 1'b0;
    end else begin
      // Result registers are live only for the single DONE cycle.
      wb_valid_q  <= 1'b0;
      wb_tag_q    <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_ecode_q <= '0;
      exc_badv_q  <= '0;
      ll_q        <= 1'b0;
      sc_q        <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            is_sc_q <= bus.op_is_sc;
            addr_q  <= bus.op_addr;
            wdata_q <= bus.op_wdata;
            tag_q   <= bus.op_tag;
            if (is_misaligned(bus.op_addr[WORD_OFS_W-1:0])) begin
              state_q     <= S_DONE;
              exc_valid_q <= 1'b1;
              exc_ecode_q <= ECODE_ALE;
              exc_badv_q  <= bus.op_addr;
            end else if (bus.op_is_sc && !bus.llbit_i) begin
              // Reservation already lost: SC fails without touching memory.
              state_q    <= S_DONE;
              wb_valid_q <= 1'b1;
              wb_tag_q   <= bus.op_tag;
              sc_q       <= 1'b1;
            end else begin
              state_q <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (bus.flush) begin
            state_q <= bus.mem_req_ready ? S_DRAIN : S_IDLE;
          end else if (bus.mem_req_ready) begin
            state_q <= S_RESP;
          end
        end

        S_RESP: begin
          if (bus.mem_resp_valid) begin
            if (bus.flush) begin
              state_q <= S_IDLE;
            end else begin
              state_q    <= S_DONE;
              wb_valid_q <= 1'b1;
              wb_tag_q   <= tag_q;
              if (is_sc_q) begin
                wb_data_q <= 32'd1;
                sc_q      <= 1'b1;
              end else begin
                wb_data_q <= bus.mem_resp_rdata;
                ll_q      <= 1'b1;
              end
            end
          end else if (bus.flush) begin
            state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (bus.mem_resp_valid) state_q <= S_IDLE;
        end

        S_DONE:  state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.op_ready      = op_ready_w;
  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_req_we    = is_sc_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;

  // A flush during DONE kills the result and the LLBCTL pulse.
  assign bus.wb_valid  = wb_valid_q && !bus.flush;
  assign bus.wb_tag    = wb_tag_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.exc_valid = exc_valid_q && !bus.flush;
  assign bus.exc_ecode = exc_ecode_q;
  assign bus.exc_badv  = exc_badv_q;
  assign bus.ll_o      = ll_q && !bus.flush;
  assign bus.sc_o      = sc_q && !bus.flush;

endmodule

// File: doc/llsc_unit.md
# llsc_unit

Atomic-access execution unit for LL.W / SC.W, sitting directly upstream of the LLBCTL CSR. It takes the oldest (non-speculative) LL/SC op from the issue stage. It checks word alignment, reads the current LLbit to decide SC success, and performs the memory access over a valid/ready request / response handshake. It then writes back the result and emits the single-cycle `ll_o` / `sc_o` pulses that LLBCTL consumes.

## Interface
- `ADDR_W`, 32: address width.
- `TAG_W`, 6: physical destination register tag width.
- `clk` in 1: single clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: op offered; only asserted for the ROB-head instruction.
- `op_ready` out 1: unit can accept; high only in IDLE with `flush` low.
- `op_is_sc` in 1: 1 = SC.W, 0 = LL.W.
- `op_addr` in ADDR_W: effective address.
- `op_wdata` in 32: SC store data.
- `op_tag` in TAG_W: destination tag.
- `llbit_i` in 1: LLBCTL[0].
- `flush` in 1: pipeline flush; cancels the in-flight op.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_we` out 1, `mem_req_addr` out ADDR_W, `mem_req_wdata` out 32: memory request channel.
- `mem_resp_valid` in 1, `mem_resp_rdata` in 32: response; one per request, no backpressure.
- `wb_valid` out 1, `wb_tag` out TAG_W, `wb_data` out 32: writeback; single-cycle, no backpressure.
- `exc_valid` out 1, `exc_ecode` out 6, `exc_badv` out ADDR_W: ALE exception report.
- `ll_o` out 1, `sc_o` out 1: pulses to LLBCTL.

## Operation
- States: IDLE, REQ, RESP, DRAIN, DONE.
- Accept (`op_valid & op_ready`) latches op, addr, wdata, tag, and `llbit_i`.
- Misaligned (`op_addr[1:0]!=0`): go to DONE. In DONE: `exc_valid=1`, `exc_ecode=ECODE_ALE (6'h09)`, `exc_badv=addr`. No `wb_valid`, no memory request, no `ll_o`/`sc_o`.
- SC with latched LLbit=0: go to DONE with `wb_data=0`, no memory access, `sc_o=1`.
- LL, or SC with LLbit=1: go to REQ.
  - `mem_req_valid=1`; `mem_req_we=op_is_sc`; addr and wdata held stable until `mem_req_ready`.
  - Then go to RESP.
- RESP: wait for `mem_resp_valid`; capture rdata; go to DONE.
- DONE (one cycle): `wb_valid=1`, `wb_tag=tag`.
  - LL: `wb_data=rdata`, `ll_o=1`.
  - Successful SC: `wb_data=1`, `sc_o=1`.
  - Return to IDLE.
- Flush, by state:
  - In REQ before the handshake: return to IDLE; no request is issued.
  - In REQ on the handshake cycle, or in RESP: go to DRAIN, which discards exactly one response and then returns to IDLE.
  - In DONE: suppresses `wb_valid`, `exc_valid`, `ll_o` and `sc_o`; go to IDLE.
- `op_ready` is low during flush, so no accept happens in a flush cycle.
- A response arriving in the same cycle as a flush in RESP is consumed: go to IDLE, not DRAIN.
- Reset values: state IDLE; all valid/pulse outputs 0; data outputs 0; `op_ready=1` after reset.

## Timing
- Accept at T; REQ is visible at T+1.
- SC-fail and ALE: `wb_valid`/`exc_valid` at T+1.
- LL / successful SC with `mem_req_ready` at T+1 and response at T+2: `wb_valid` at T+3.
- Each memory stall cycle adds one cycle.
- `ll_o`/`sc_o` are coincident with `wb_valid`, so LLBCTL updates at T+4 for the memory case.
- Back-to-back ops: next accept is no earlier than the cycle after DONE (`op_ready` is high in IDLE only).
- `llbit_i` is sampled only at accept; later changes do not affect the decision.

## Structure
- Shared package `llsc_pkg`:
  - state enum;
  - `ECODE_ALE`;
  - `MEM_WORD_BYTES=4`.
- No sub-module; single FSM plus latch registers.

## Test plan
- LL at 0x1000, mem returns 0xDEADBEEF after 1 stall → `mem_req_we=0`, `wb_data=0xDEADBEEF`, `ll_o=1` with `wb_valid`, `sc_o=0`.
- SC at 0x1000, wdata 0x55, `llbit_i=1` → store request with wdata 0x55, `wb_data=1`, `sc_o=1`.
- SC with `llbit_i=0` → no `mem_req_valid` ever; `wb_data=0` at T+1; `sc_o=1`.
- LL at 0x1002 → `exc_valid=1`, `exc_ecode=0x09`, `exc_badv=0x1002`; `wb_valid`, `ll_o` and `mem_req_valid` stay 0.
- Flush while in RESP, response two cycles later → response dropped; no `wb_valid`/`ll_o`; `op_ready` high the cycle after the response.
- Reset asserted mid-RESP → next cycle state IDLE, all outputs 0, `op_ready=1`; a new LL completes normally.
